// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register with a two-entry skid buffer; ready_f is registered so
// decode stalls never reach fetch combinationally. Also counts decode-stall cycles.
module fetch_decode_reg #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_f,
    input  logic [XLEN-1:0]  instr_f,
    input  logic             pred_taken_f,
    input  logic             valid_f,
    output logic             ready_f,
    input  logic             flush_fd,
    input  logic             stall_d,
    output logic [XLEN-1:0]  pc_d,
    output logic [XLEN-1:0]  instr_d,
    output logic             pred_taken_d,
    output logic             valid_d,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, next_state;
    logic [XLEN-1:0]   skid_pc, skid_instr;
    logic              skid_pred;
    logic              accept, consume;

    assign accept  = valid_f & ready_f;
    assign consume = valid_d & ~stall_d;

    always_comb begin
        next_state = state;
        if (flush_fd) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) next_state = ONE;
                ONE: begin
                    if (accept && !consume)      next_state = TWO;
                    else if (!accept && consume) next_state = EMPTY;
                end
                TWO:     if (consume) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= EMPTY;
            ready_f      <= 1'b1;
            valid_d      <= 1'b0;
            pc_d         <= '0;
            instr_d      <= NOP_INSTR;
            pred_taken_d <= 1'b0;
            skid_pc      <= '0;
            skid_instr   <= NOP_INSTR;
            skid_pred    <= 1'b0;
            stall_cnt    <= '0;
        end else begin
            state   <= next_state;
            ready_f <= (next_state != TWO);

            // Counter is independent of flush; saturates at all-ones
            if (valid_d && stall_d && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;

            if (flush_fd) begin
                valid_d      <= 1'b0;
                instr_d      <= NOP_INSTR;
                pred_taken_d <= 1'b0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            valid_d      <= 1'b1;
                            pc_d         <= pc_f;
                            instr_d      <= instr_f;
                            pred_taken_d <= pred_taken_f;
                        end
                    end
                    ONE: begin
                        if (accept && consume) begin
                            pc_d         <= pc_f;
                            instr_d      <= instr_f;
                            pred_taken_d <= pred_taken_f;
                        end else if (accept) begin
                            skid_pc    <= pc_f;
                            skid_instr <= instr_f;
                            skid_pred  <= pred_taken_f;
                        end else if (consume) begin
                            valid_d      <= 1'b0;
                            instr_d      <= NOP_INSTR;
                            pred_taken_d <= 1'b0;
                        end
                    end
                    TWO: begin
                        if (consume) begin
                            pc_d         <= skid_pc;
                            instr_d      <= skid_instr;
                            pred_taken_d <= skid_pred;
                        end
                    end
                    default: begin
                        valid_d      <= 1'b0;
                        instr_d      <= NOP_INSTR;
                        pred_taken_d <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed bench for fetch_decode_reg: streaming, stall fill/drain, flush,
// async reset mid-operation and stall counter saturation.
module tb_fetch_decode_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  pc_f, instr_f;
    logic             pred_taken_f, valid_f, flush_fd, stall_d;
    logic             ready_f;
    logic [XLEN-1:0]  pc_d, instr_d;
    logic             pred_taken_d, valid_d;
    logic [CNT_W-1:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    fetch_decode_reg #(.XLEN(XLEN), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pc_f(pc_f), .instr_f(instr_f), .pred_taken_f(pred_taken_f),
        .valid_f(valid_f), .ready_f(ready_f),
        .flush_fd(flush_fd), .stall_d(stall_d),
        .pc_d(pc_d), .instr_d(instr_d), .pred_taken_d(pred_taken_d),
        .valid_d(valid_d), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction word and prediction bit are derived from the PC
    task automatic drive(input logic v, input logic [31:0] pc);
        valid_f      = v;
        pc_f         = pc;
        instr_f      = pc | 32'hA000_0000;
        pred_taken_f = pc[2];
    endtask

    initial begin
        rst = 1'b0; flush_fd = 1'b0; stall_d = 1'b0;
        drive(1'b0, 32'h0);
        #12;
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pc", pc_d, 32'h0);
        chk("rst_pred", {31'b0, pred_taken_d}, 32'h0);
        chk("rst_ready", {31'b0, ready_f}, 32'h1);
        chk("rst_cnt", {16'b0, stall_cnt}, 32'h0);
        rst = 1'b1;
        step();

        // 1: streaming
        drive(1'b1, 32'h00); step();
        chk("s_pc0", pc_d, 32'h00);
        chk("s_v0", {31'b0, valid_d}, 32'h1);
        chk("s_i0", instr_d, 32'hA000_0000);
        drive(1'b1, 32'h04); step();
        chk("s_pc4", pc_d, 32'h04);
        chk("s_pred4", {31'b0, pred_taken_d}, 32'h1);
        chk("s_rdy4", {31'b0, ready_f}, 32'h1);
        drive(1'b1, 32'h08); step();
        chk("s_pc8", pc_d, 32'h08);
        chk("s_rdy8", {31'b0, ready_f}, 32'h1);
        drive(1'b0, 32'h0); step();
        chk("s_drain_v", {31'b0, valid_d}, 32'h0);
        chk("s_drain_i", instr_d, NOP);

        // 2: stall fill and drain
        drive(1'b1, 32'h10); stall_d = 1'b1; step();
        chk("f_pc10", pc_d, 32'h10);
        drive(1'b1, 32'h14); step();
        chk("f_rdy_two", {31'b0, ready_f}, 32'h0);
        drive(1'b1, 32'h18); step();
        chk("f_hold", pc_d, 32'h10);
        chk("f_cnt2", {16'b0, stall_cnt}, 32'h2);
        step();
        chk("f_hold2", pc_d, 32'h10);
        chk("f_rdy0", {31'b0, ready_f}, 32'h0);
        stall_d = 1'b0; step();
        chk("f_pc14", pc_d, 32'h14);
        chk("f_rdy1", {31'b0, ready_f}, 32'h1);
        step();
        chk("f_pc18", pc_d, 32'h18);
        chk("f_i18", instr_d, 32'hA000_0018);
        drive(1'b0, 32'h0); step();
        chk("f_empty", {31'b0, valid_d}, 32'h0);
        chk("f_cnt3", {16'b0, stall_cnt}, 32'h3);

        // 3: flush in TWO drops everything including the concurrent input
        drive(1'b1, 32'h30); stall_d = 1'b1; step();
        drive(1'b1, 32'h34); step();
        chk("fl_rdy_two", {31'b0, ready_f}, 32'h0);
        drive(1'b1, 32'h20); flush_fd = 1'b1; step();
        chk("fl_valid", {31'b0, valid_d}, 32'h0);
        chk("fl_instr", instr_d, NOP);
        chk("fl_pred", {31'b0, pred_taken_d}, 32'h0);
        chk("fl_pc_hold", pc_d, 32'h30);
        chk("fl_ready", {31'b0, ready_f}, 32'h1);
        chk("fl_cnt5", {16'b0, stall_cnt}, 32'h5);
        flush_fd = 1'b0; drive(1'b0, 32'h0); step();
        chk("fl_dropped", {31'b0, valid_d}, 32'h0);

        // 4: async reset mid-cycle while in TWO
        drive(1'b1, 32'h40); step();
        drive(1'b1, 32'h44); step();
        chk("ar_two", {31'b0, ready_f}, 32'h0);
        chk("ar_pc40", pc_d, 32'h40);
        drive(1'b0, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", {31'b0, valid_d}, 32'h0);
        chk("ar_instr", instr_d, NOP);
        chk("ar_pc", pc_d, 32'h0);
        chk("ar_ready", {31'b0, ready_f}, 32'h1);
        chk("ar_cnt", {16'b0, stall_cnt}, 32'h0);
        #2 rst = 1'b1;
        step();
        chk("ar_after", {31'b0, valid_d}, 32'h0);

        // 5: stall counter saturation
        drive(1'b1, 32'h50); stall_d = 1'b1; step();
        drive(1'b0, 32'h0);
        repeat (65534) step();
        chk("sat_fffe", {16'b0, stall_cnt}, 32'hFFFE);
        step();
        chk("sat_ffff", {16'b0, stall_cnt}, 32'hFFFF);
        repeat (4500) step();
        chk("sat_stay", {16'b0, stall_cnt}, 32'hFFFF);
        chk("sat_pc", pc_d, 32'h50);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
